stream_mux_rr: RTL
==================

// Module: stream_mux_rr
// PURPOSE
//  N-channel, W-bit registered stream multiplexer with valid/ready handshake on every port.
//  Generalises the CPU's combinational 4:1 16-bit mux to N channels.
//  Adds an output pipeline register, backpressure, and a runtime-selectable mode:
//  fixed select (sel) or round-robin arbitration.
//  Sits between datapath producers (ALU, memory read, immediate path) and a shared consumer
//  (register-file write port or memory interface).
// PARAMETERS
//  N_CH    4   number of input channels, 2..16
//  DATA_W  16  data width per channel
//  SEL_W   $clog2(N_CH)  select/grant index width (derived; do not override)
// PORTS
//  clk        in   1            clock, rising edge
//  rst        in   1            asynchronous, active-high reset
//  mode_rr    in   1            0 = fixed select via sel; 1 = round-robin
//  sel        in   SEL_W        channel index in fixed mode; ignored when mode_rr=1
//  in_valid   in   N_CH         per-channel valid
//  in_data    in   N_CH*DATA_W  channel i at [i*DATA_W +: DATA_W]
//  in_ready   out  N_CH         per-channel ready; one-hot or zero
//  out_valid  out  1            output register holds a word
//  out_data   out  DATA_W       registered data
//  out_grant  out  SEL_W        index of the channel that supplied out_data
//  out_ready  in   1            consumer accepts out_data
// BEHAVIOUR
//  Reset (async assert, sync release): out_valid=0, out_data=0, out_grant=0, rr_ptr=N_CH-1.
//   With rr_ptr=N_CH-1, channel 0 has first round-robin priority.
//  Can-load: load_en = !out_valid || out_ready.
//   in_ready is combinational from out_ready, mode_rr, sel and in_valid; it is never registered.
//  Channel choice in fixed mode: cand = sel.
//   If sel >= N_CH (non-power-of-2 N_CH), no channel is chosen and in_ready = 0.
//  Channel choice in RR mode: cand = first i with in_valid[i]=1, scanning rr_ptr+1, rr_ptr+2, ...
//   The scan wraps modulo N_CH. If no channel is valid, none is chosen.
//  in_ready[cand] = load_en. In RR mode, in_ready[cand] is also gated by in_valid[cand].
//   All other in_ready bits are 0.
//  Input transfer: in_valid[i] && in_ready[i] at a rising edge. On transfer:
//   out_data <= channel i data, out_grant <= i, out_valid <= 1.
//   rr_ptr <= i, but only in RR mode.
//  Output transfer: out_valid && out_ready at a rising edge.
//   out_valid <= 0 unless an input transfer happens in the same cycle; the register then reloads.
//  Latency: 1 cycle input->output. Throughput: 1 word/cycle while out_ready stays high.
//  Stall: while out_valid && !out_ready, all of out_data, out_grant and out_valid hold,
//   and in_ready = 0.
//  Mode or sel changes take effect on the next load only. A held output word is never altered.
//  Fixed mode never changes rr_ptr. Switching back to RR resumes from the last RR grant.
//  in_data is ignored on channels whose valid is low.
//  Reset mid-transfer: the pending word is discarded and outputs return to reset values
//   immediately, without waiting for a clock edge.
// STRUCTURE
//  Shared package cpu_mux_pkg holds:
//   localparam DEFAULT_DATA_W=16
//   typedef enum logic {MUX_FIXED=1'b0, MUX_RR=1'b1} mux_mode_e
//  Sub-module rr_arbiter #(N_CH): inputs req[N_CH] and ptr; outputs gnt one-hot and gnt_idx.
//   Purely combinational; implemented as a double-width rotate + priority encode.
//  The top level holds the output register, rr_ptr, the fixed/RR choice mux and ready gating.
// TESTING
//  Defaults: N_CH=4, DATA_W=16, data = AAAA, BBBB, CCCC, DDDD on ch0..3; out_ready=1
//  unless stated otherwise.
//  1 Fixed mode, all valid, sel steps 0,1,2,3 -> out_data AAAA,BBBB,CCCC,DDDD.
//    Each word arrives one cycle after its sel; out_grant tracks sel;
//    only in_ready[sel] is high.
//  2 RR mode, all four valid for 8 cycles -> grants 0,1,2,3,0,1,2,3.
//    out_data cycles AAAA..DDDD; no channel is granted twice before all four are served.
//  3 RR mode, only ch1 and ch3 valid -> grants alternate 1,3,1,3.
//    in_ready[0] and in_ready[2] stay 0.
//  4 Backpressure: load BBBB, then hold out_ready=0 for 3 cycles ->
//    out_data=BBBB and out_valid=1 held, in_ready=0.
//    Releasing out_ready gives BBBB accepted plus a new word loaded in the same edge
//    (back-to-back, no bubble).
//  5 Fixed mode with sel=2 and in_valid[2]=0 -> no transfer.
//    out_valid falls after the pending word drains; other valid channels are not taken.
//  6 Assert rst while out_valid=1 with out_data=CCCC ->
//    out_valid=0, out_data=0000, out_grant=0 asynchronously.
//    After release, the first RR grant goes to ch0.

Source files
------------

// File: rtl/cpu_mux_pkg.sv
// Shared types and defaults for the CPU datapath stream multiplexers.
package cpu_mux_pkg;

  localparam int unsigned DEFAULT_DATA_W = 16;

  typedef enum logic {
    MUX_FIXED = 1'b0,
    MUX_RR    = 1'b1
  } mux_mode_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr, wrapping.
module rr_arbiter
  import cpu_mux_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  gnt,
  output logic [SEL_W-1:0] gnt_idx
);

  logic [2*N_CH-1:0] dbl;
  logic [N_CH-1:0]   rot;
  logic              found;
  int unsigned       pos;

  // Rotate so bit 0 is the channel just after ptr, then take the lowest set bit.
  always_comb begin
    dbl     = {req, req} >> (32'(ptr) + 32'd1);
    rot     = dbl[N_CH-1:0];
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = 0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        pos   = (32'(ptr) + 32'd1 + k) % N_CH;
      end
    end
    if (found) begin
      gnt     = N_CH'(1) << pos;
      gnt_idx = SEL_W'(pos);
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel registered stream mux with valid/ready handshakes and
// runtime choice between fixed select and round-robin arbitration.
module stream_mux_rr
  import cpu_mux_pkg::*;
#(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned SEL_W  = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode_rr,
  input  logic [SEL_W-1:0]         sel,
  input  logic [N_CH-1:0]          in_valid,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  output logic [N_CH-1:0]          in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_grant,
  input  logic                     out_ready
);

  logic [SEL_W-1:0]  rr_ptr;
  logic [N_CH-1:0]   rr_gnt;
  logic [SEL_W-1:0]  rr_idx;
  logic              load_en;
  logic              cand_ok;
  logic [SEL_W-1:0]  cand;
  logic [DATA_W-1:0] cand_data;
  logic              xfer;
  logic              is_rr;

  assign is_rr = (mux_mode_e'(mode_rr) == MUX_RR);

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx)
  );

  // Candidate channel and ready gating; ready only opens when the output register can load.
  always_comb begin
    load_en   = !out_valid || out_ready;
    cand      = '0;
    cand_ok   = 1'b0;
    in_ready  = '0;
    cand_data = '0;
    if (is_rr) begin
      cand    = rr_idx;
      cand_ok = |rr_gnt;
    end else begin
      cand    = sel;
      cand_ok = (32'(sel) < N_CH);
    end
    if (cand_ok && load_en) begin
      in_ready = N_CH'(1) << cand;
    end
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (cand == SEL_W'(i)) begin
        cand_data = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign xfer = |(in_valid & in_ready);

  // Output register and round-robin pointer; fixed-mode loads leave the pointer alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_grant <= '0;
      rr_ptr    <= SEL_W'(N_CH - 1);
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= cand_data;
        out_grant <= cand;
        if (is_rr) begin
          rr_ptr <= cand;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
